saturn_bus_program_builder: RTL and testbench
=============================================

Name: saturn_bus_program_builder

Overview:
Sequencer that turns high-level bus requests from the control unit into the 5-bit bus program list: {1,cmd} words and {0,nibble} data words. The bus controller drains the list. The block owns a circular program buffer and its write pointer. The bus controller reads it through its own read pointer, and the block stalls requesters when the buffer would overflow.

Parameters:
PTR_W, 5, pointer width; buffer depth = 2**PTR_W words (32)
ADDR_NIBBLES, 5, number of address nibbles emitted after an addressed command (20-bit Saturn address)

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_clk_en  in  1  clock enable; all state advances only when high
i_req_valid  in  1  request present
o_req_ready  out  1  builder can accept a request this cycle
i_req_op  in  4  bus command nibble: 2 PC_READ, 3 DP_READ, 4 PC_WRITE, 5 DP_WRITE, 6 LOAD_PC, 7 LOAD_DP, 8 CONFIGURE, 9 UNCONFIGURE, F RESET; other values are also emitted verbatim
i_req_addr  in  20  address for addressed ops (6, 7, 8)
o_prog_addr  out  PTR_W  write pointer: index of next word to be written
i_prog_rd_addr  in  PTR_W  bus controller read pointer (next word it will consume)
o_prog_data  out  5  buffer word at i_prog_rd_addr (combinational read)
o_busy  out  1  request in progress or buffer not drained (o_prog_addr != i_prog_rd_addr)
o_overflow  out  1  sticky error flag, see below

Behaviour:
- Reset (async, i_reset_n low): state IDLE; o_prog_addr=0; o_req_ready=0 (asserts once state is IDLE and i_reset_n is high); o_busy=0; o_overflow=0. Buffer contents are not cleared.
- Interaction with the bus controller's pointer reset:
  - The bus controller resets its read pointer to 0, so after reset the buffer is empty (o_prog_addr == i_prog_rd_addr).
  - Reset mid-request abandons the request; no partial words survive the pointer reset.
- o_req_ready = (state==IDLE); combinational.
- Accept: i_clk_en & i_req_valid & o_req_ready.
  - Latch op and addr; go to CMD.
  - A request not accepted (ready low) is not latched; the requester must hold it.
- Full: full = (o_prog_addr + 1) mod 2**PTR_W == i_prog_rd_addr. One slot is always kept empty.
- CMD, on an enabled cycle:
  - If full: stall, write nothing.
  - Else write {1'b1, op} at o_prog_addr and increment o_prog_addr (wraps 31->0).
  - Then go to ADDR (nibble counter = 0) if op is 6, 7 or 8; otherwise go to IDLE.
- ADDR, on an enabled cycle:
  - If full: stall.
  - Else write {1'b0, addr[4*n+3:4*n]} with n = counter (LSB nibble first), increment pointer and counter.
  - After nibble ADDR_NIBBLES-1, go to IDLE.
- Throughput: one word per enabled cycle when not full.
  - Addressed op: 1+5 = 6 enabled cycles after accept.
  - Simple op: 1 enabled cycle after accept.
  - Next accept is possible the enabled cycle after returning to IDLE.
- i_clk_en low: every register holds, including a stalled state.
- Simultaneous write and read-pointer advance: full is evaluated on the current i_prog_rd_addr only. A slot freed in the same cycle is used on the next cycle.
- o_overflow:
  - Set if i_prog_rd_addr moves past o_prog_addr, i.e. the consumer reads an unwritten word.
  - Detected as: the previous cycle was empty (rd == wr) and rd changed while no write happened.
  - Sticky until reset. Intended to feed o_halt.
- o_busy = (state != IDLE) | (o_prog_addr != i_prog_rd_addr).

Test Plan:
- Reset, then LOAD_PC addr 0x12345 with i_clk_en=1 and read pointer held at 0 -> words 0x16, 0x05, 0x04, 0x03, 0x02, 0x01 at indices 0-5; o_prog_addr=6 after 6 enabled cycles; ready low throughout, high after.
- PC_READ after reset -> single word 0x12 at index 0; o_prog_addr=1; ready returns the next cycle; o_busy stays 1 until i_prog_rd_addr=1.
- Read pointer held at 0, LOAD_DP requests issued repeatedly -> writing stops at o_prog_addr=31 (full); state holds in ADDR. Advancing rd to 1 -> one more word written, o_prog_addr wraps to 0.
- i_clk_en toggled 1-0-1 during LOAD_DP addr 0xABCDE -> identical word sequence (0x17, 0x0E, 0x0D, 0x0C, 0x0B, 0x0A); no state change on disabled cycles.
- i_reset_n pulsed low after 3 words of a CONFIGURE -> immediately o_prog_addr=0, IDLE, ready high after release; a fresh request starts writing at index 0.
- Empty buffer with rd stepped from 4 to 5 without a write -> o_overflow=1, remaining 1 until reset.

Source files
------------

// File: rtl/saturn_bus_program_builder.sv
// rtl/saturn_bus_program_builder.sv - bus program list builder for Saturn bus requests
//
// Turns control-unit bus requests into the 5-bit bus program list consumed by
// the bus controller: a {1,cmd} word followed, for addressed ops, by
// ADDR_NIBBLES {0,nibble} words (LSB nibble first). The block owns a circular
// buffer and its write pointer; the bus controller owns the read pointer.
//
// Ports:
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   i_clk_en       clock enable, all state advances only when high
//   i_req_valid    request present
//   o_req_ready    builder is idle and can accept a request
//   i_req_op       bus command nibble (6/7/8 carry an address)
//   i_req_addr     address for addressed ops
//   o_prog_addr    write pointer, index of next word to be written
//   i_prog_rd_addr bus controller read pointer
//   o_prog_data    buffer word at i_prog_rd_addr (combinational)
//   o_busy         request in progress or buffer not drained
//   o_overflow     sticky: consumer read an unwritten word
module saturn_bus_program_builder #(
  parameter int PTR_W        = 5,
  parameter int ADDR_NIBBLES = 5
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_clk_en,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [3:0]                i_req_op,
  input  logic [4*ADDR_NIBBLES-1:0] i_req_addr,
  output logic [PTR_W-1:0]          o_prog_addr,
  input  logic [PTR_W-1:0]          i_prog_rd_addr,
  output logic [4:0]                o_prog_data,
  output logic                      o_busy,
  output logic                      o_overflow
);

  localparam int DEPTH = 2 ** PTR_W;
  localparam int CNT_W = (ADDR_NIBBLES > 1) ? $clog2(ADDR_NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(ADDR_NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    ADDR = 2'd2
  } state_t;

  state_t state, next_state;

  logic [4:0]                mem [DEPTH];
  logic [3:0]                op_q;
  logic [4*ADDR_NIBBLES-1:0] addr_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_q;
  logic                      last_empty_q;
  logic                      overflow_q;

  logic                      full;
  logic                      addressed;
  logic                      accept;
  logic                      we;
  logic [4:0]                wdata;
  logic [4*ADDR_NIBBLES-1:0] addr_sh;

  // One slot always stays empty so that wr == rd unambiguously means empty.
  assign full      = (wr_ptr + PTR_W'(1)) == i_prog_rd_addr;
  assign addressed = (op_q == 4'h6) || (op_q == 4'h7) || (op_q == 4'h8);
  assign addr_sh   = addr_q >> {cnt_q, 2'b00};

  assign o_req_ready = (state == IDLE) && i_reset_n;
  assign accept      = i_clk_en && i_req_valid && o_req_ready;
  assign o_prog_addr = wr_ptr;
  assign o_prog_data = mem[i_prog_rd_addr];
  assign o_busy      = (state != IDLE) || (wr_ptr != i_prog_rd_addr);
  assign o_overflow  = overflow_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    we         = 1'b0;
    wdata      = {1'b0, addr_sh[3:0]};
    case (state)
      IDLE: begin
        if (accept) next_state = CMD;
      end
      CMD: begin
        wdata = {1'b1, op_q};
        if (i_clk_en && !full) begin
          we         = 1'b1;
          next_state = addressed ? ADDR : IDLE;
        end
      end
      ADDR: begin
        if (i_clk_en && !full) begin
          we = 1'b1;
          if (cnt_q == LAST_NIB) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      op_q         <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      wr_ptr       <= '0;
      rd_q         <= '0;
      last_empty_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (i_clk_en) begin
      if (accept) begin
        op_q   <= i_req_op;
        addr_q <= i_req_addr;
      end
      if (we) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        cnt_q  <= (state == CMD) ? '0 : cnt_q + CNT_W'(1);
      end
      // Consumer moved while the buffer was empty and nothing was written:
      // it has read a word that was never produced.
      rd_q         <= i_prog_rd_addr;
      last_empty_q <= (i_prog_rd_addr == wr_ptr) && !we;
      if (last_empty_q && (i_prog_rd_addr != rd_q)) overflow_q <= 1'b1;
    end
  end

  // Buffer contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (we) mem[wr_ptr] <= wdata;
  end

endmodule

// File: tb/tb_saturn_bus_program_builder.sv
// tb/tb_saturn_bus_program_builder.sv - directed self-checking bench for saturn_bus_program_builder
module tb_saturn_bus_program_builder;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_clk_en;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [3:0]  i_req_op;
  logic [19:0] i_req_addr;
  logic [4:0]  o_prog_addr;
  logic [4:0]  i_prog_rd_addr;
  logic [4:0]  o_prog_data;
  logic        o_busy;
  logic        o_overflow;

  int checks;
  int failures;

  saturn_bus_program_builder #(.PTR_W(5), .ADDR_NIBBLES(5)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_clk_en      (i_clk_en),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_op      (i_req_op),
    .i_req_addr    (i_req_addr),
    .o_prog_addr   (o_prog_addr),
    .i_prog_rd_addr(i_prog_rd_addr),
    .o_prog_data   (o_prog_data),
    .o_busy        (o_busy),
    .o_overflow    (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset_n      = 1'b0;
    i_clk_en       = 1'b1;
    i_req_valid    = 1'b0;
    i_req_op       = 4'h0;
    i_req_addr     = 20'h0;
    i_prog_rd_addr = 5'd0;
    tick();
    i_reset_n = 1'b1;
    #1;
  endtask

  // Reads buffer words with the clock disabled so the scan cannot disturb state.
  task automatic read_word(input string tag, input logic [4:0] idx, input logic [4:0] exp);
    logic [4:0] saved_rd;
    logic       saved_en;
    saved_rd       = i_prog_rd_addr;
    saved_en       = i_clk_en;
    i_clk_en       = 1'b0;
    i_prog_rd_addr = idx;
    #1;
    check(tag, 32'(o_prog_data), 32'(exp));
    i_prog_rd_addr = saved_rd;
    i_clk_en       = saved_en;
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [19:0] addr);
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_addr  = addr;
    tick();
    i_req_valid = 1'b0;
  endtask

  logic [4:0] exp_words [6];

  initial begin
    checks   = 0;
    failures = 0;

    // Reset values while reset is held
    i_reset_n      = 1'b0;
    i_clk_en       = 1'b1;
    i_req_valid    = 1'b0;
    i_req_op       = 4'h0;
    i_req_addr     = 20'h0;
    i_prog_rd_addr = 5'd0;
    #2;
    check("rst_ready", 32'(o_req_ready), 32'd0);
    check("rst_addr", 32'(o_prog_addr), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    tick();
    i_reset_n = 1'b1;
    #1;
    check("rst_ready_rel", 32'(o_req_ready), 32'd1);

    // LOAD_PC 0x12345
    issue(4'h6, 20'h12345);
    check("ldpc_ready_acc", 32'(o_req_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 5) check($sformatf("ldpc_ready_%0d", i), 32'(o_req_ready), 32'd0);
    end
    check("ldpc_ready_end", 32'(o_req_ready), 32'd1);
    check("ldpc_addr", 32'(o_prog_addr), 32'd6);
    exp_words = '{5'h16, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01};
    for (int i = 0; i < 6; i++) read_word($sformatf("ldpc_w%0d", i), 5'(i), exp_words[i]);
    i_prog_rd_addr = 5'd6;
    tick();
    check("ldpc_ovf", 32'(o_overflow), 32'd0);

    // PC_READ single word
    do_reset();
    issue(4'h2, 20'hFFFFF);
    tick();
    check("pcr_addr", 32'(o_prog_addr), 32'd1);
    check("pcr_ready", 32'(o_req_ready), 32'd1);
    check("pcr_busy", 32'(o_busy), 32'd1);
    check("pcr_data", 32'(o_prog_data), 32'h12);
    tick();
    check("pcr_busy_hold", 32'(o_busy), 32'd1);
    i_prog_rd_addr = 5'd1;
    #1;
    check("pcr_busy_drained", 32'(o_busy), 32'd0);

    // Fill to full with repeated LOAD_DP, read pointer held at 0
    do_reset();
    i_req_valid = 1'b1;
    i_req_op    = 4'h7;
    i_req_addr  = 20'h54321;
    for (int i = 0; i < 45; i++) tick();
    i_req_valid = 1'b0;
    check("full_addr", 32'(o_prog_addr), 32'd31);
    check("full_ready", 32'(o_req_ready), 32'd0);
    check("full_busy", 32'(o_busy), 32'd1);
    read_word("full_w30", 5'd30, 5'h17);
    read_word("full_w29", 5'd29, 5'h05);
    tick();
    check("full_hold", 32'(o_prog_addr), 32'd31);
    i_prog_rd_addr = 5'd1;
    tick();
    check("full_wrap", 32'(o_prog_addr), 32'd0);
    read_word("full_w31", 5'd31, 5'h01);
    tick();
    check("full_stall2", 32'(o_prog_addr), 32'd0);
    check("full_ovf", 32'(o_overflow), 32'd0);

    // Clock enable toggling during LOAD_DP 0xABCDE
    do_reset();
    i_clk_en    = 1'b0;
    i_req_valid = 1'b1;
    i_req_op    = 4'h7;
    i_req_addr  = 20'hABCDE;
    tick();
    check("en_noacc", 32'(o_req_ready), 32'd1);
    i_clk_en = 1'b1;
    tick();
    i_req_valid = 1'b0;
    i_req_addr  = 20'h00000;
    for (int i = 0; i < 6; i++) begin
      i_clk_en = 1'b0;
      tick();
      check($sformatf("en_off_addr_%0d", i), 32'(o_prog_addr), 32'(i));
      check($sformatf("en_off_ready_%0d", i), 32'(o_req_ready), 32'd0);
      i_clk_en = 1'b1;
      tick();
      check($sformatf("en_on_addr_%0d", i), 32'(o_prog_addr), 32'(i + 1));
    end
    check("en_ready_end", 32'(o_req_ready), 32'd1);
    exp_words = '{5'h17, 5'h0E, 5'h0D, 5'h0C, 5'h0B, 5'h0A};
    for (int i = 0; i < 6; i++) read_word($sformatf("en_w%0d", i), 5'(i), exp_words[i]);

    // Reset in the middle of CONFIGURE
    do_reset();
    issue(4'h8, 20'h9ABCD);
    for (int i = 0; i < 3; i++) tick();
    check("cfg_addr3", 32'(o_prog_addr), 32'd3);
    i_reset_n = 1'b0;
    #1;
    check("cfg_rst_addr", 32'(o_prog_addr), 32'd0);
    check("cfg_rst_ready", 32'(o_req_ready), 32'd0);
    check("cfg_rst_busy", 32'(o_busy), 32'd0);
    tick();
    i_reset_n = 1'b1;
    #1;
    check("cfg_rel_ready", 32'(o_req_ready), 32'd1);
    issue(4'h4, 20'h0);
    tick();
    check("cfg_fresh_addr", 32'(o_prog_addr), 32'd1);
    check("cfg_fresh_data", 32'(o_prog_data), 32'h14);

    // Overflow: consumer steps past the write pointer on an empty buffer
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(4'hF, 20'h0);
      tick();
    end
    check("ovf_wr4", 32'(o_prog_addr), 32'd4);
    i_prog_rd_addr = 5'd4;
    tick();
    tick();
    check("ovf_pre", 32'(o_overflow), 32'd0);
    check("ovf_empty_busy", 32'(o_busy), 32'd0);
    i_prog_rd_addr = 5'd5;
    tick();
    check("ovf_set", 32'(o_overflow), 32'd1);
    i_prog_rd_addr = 5'd4;
    tick();
    tick();
    check("ovf_sticky", 32'(o_overflow), 32'd1);
    do_reset();
    check("ovf_cleared", 32'(o_overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
